// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   ROB_BIT / ROB_SIZE : entry index width and number of entries
//   rob_type_e         : instruction class carried by each entry
//   rob_entry_t        : contents of one buffer slot
package rob_pkg;

  localparam int ROB_BIT  = 3;
  localparam int ROB_SIZE = 1 << ROB_BIT;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_EXIT   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   kind;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] inst_addr;
    logic        pred_taken;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions kept in issue order.
// Allocates at tail on issue, captures ALU/LSB result broadcasts, retires one
// ready instruction per cycle from head, and raises a global flush when a
// retiring branch turns out to be mispredicted.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (pause when low)
//   issue_*            : allocation request and payload
//   rs_* / lsb_*       : result broadcasts (tag + value)
//   query{1,2}_*       : combinational operand lookup for the decoder
//   rob_tail/full/empty: allocation status
//   commit_*           : registered one-cycle retire pulses
//   rob_clear_up/clear_pc : flush pulse and redirect PC
//   rob_halt           : sticky, set when EXIT retires
// Handshake: every *_signal/*_ready input is a single-cycle qualifier sampled
// on the rising edge; no backpressure exists, the producer guarantees legality.
module rob
  import rob_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_signal,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [31:0]        issue_inst_addr,
  input  logic               issue_pred_taken,
  input  logic [31:0]        issue_target,
  input  logic               rs_ready,
  input  logic [ROB_BIT-1:0] rs_rob_entry,
  input  logic [31:0]        rs_value,
  input  logic               lsb_ready,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  input  logic [ROB_BIT-1:0] query1_entry,
  input  logic [ROB_BIT-1:0] query2_entry,
  output logic               query1_ready,
  output logic               query2_ready,
  output logic [31:0]        query1_value,
  output logic [31:0]        query2_value,
  output logic [ROB_BIT-1:0] rob_tail,
  output logic               rob_full,
  output logic               rob_empty,
  output logic               commit_reg_valid,
  output logic [4:0]         commit_rd,
  output logic [31:0]        commit_value,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               commit_store,
  output logic               rob_clear_up,
  output logic [31:0]        clear_pc,
  output logic               rob_halt
);

  localparam logic [ROB_BIT:0] FULL_COUNT = (ROB_BIT+1)'(ROB_SIZE);

  rob_entry_t         ent [ROB_SIZE];
  logic [ROB_BIT-1:0] head;
  logic [ROB_BIT-1:0] tail;
  logic [ROB_BIT:0]   count;

  // Pulse registers; outputs are gated by rdy_in so a paused cycle shows no
  // pulse, while the pending pulse itself survives the pause.
  logic reg_valid_q;
  logic store_q;
  logic clear_q;

  rob_entry_t head_ent;
  rob_entry_t new_ent;
  logic       do_commit;
  logic       do_issue;
  logic       mispredict;
  logic       actual_taken;

  always_comb begin
    head_ent     = ent[head];
    actual_taken = head_ent.value[0];
    do_commit    = (count != '0) && head_ent.busy && head_ent.ready &&
                   !clear_q && !rob_halt;
    mispredict   = do_commit && (head_ent.kind == ROB_BRANCH) &&
                   (actual_taken != head_ent.pred_taken);
    do_issue     = issue_signal && !clear_q;

    new_ent            = '0;
    new_ent.busy       = 1'b1;
    new_ent.kind       = rob_type_e'(issue_type);
    new_ent.ready      = (new_ent.kind == ROB_STORE) || (new_ent.kind == ROB_EXIT);
    new_ent.rd         = issue_rd;
    new_ent.inst_addr  = issue_inst_addr;
    new_ent.pred_taken = issue_pred_taken;
    new_ent.target     = issue_target;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      reg_valid_q      <= 1'b0;
      store_q          <= 1'b0;
      clear_q          <= 1'b0;
      commit_rd        <= '0;
      commit_value     <= '0;
      commit_rob_entry <= '0;
      clear_pc         <= '0;
      rob_halt         <= 1'b0;
    end else if (rdy_in) begin
      reg_valid_q <= 1'b0;
      store_q     <= 1'b0;
      clear_q     <= 1'b0;
      if (mispredict) begin
        // Everything younger than the branch is wrong-path: drop it all,
        // including anything issued or written back on this same edge.
        for (int i = 0; i < ROB_SIZE; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        clear_q  <= 1'b1;
        clear_pc <= actual_taken ? head_ent.target : head_ent.inst_addr + 32'd4;
      end else begin
        if (do_commit) begin
          ent[head].busy  <= 1'b0;
          ent[head].ready <= 1'b0;
          head            <= head + ROB_BIT'(1);
          case (head_ent.kind)
            ROB_REG: begin
              reg_valid_q      <= 1'b1;
              commit_rd        <= head_ent.rd;
              commit_value     <= head_ent.value;
              commit_rob_entry <= head;
            end
            ROB_STORE: begin
              store_q          <= 1'b1;
              commit_rob_entry <= head;
            end
            ROB_EXIT: rob_halt <= 1'b1;
            default: ;
          endcase
        end
        if (!clear_q) begin
          if (rs_ready && ent[rs_rob_entry].busy) begin
            ent[rs_rob_entry].value <= rs_value;
            ent[rs_rob_entry].ready <= 1'b1;
          end
          if (lsb_ready && ent[lsb_rob_entry].busy) begin
            ent[lsb_rob_entry].value <= lsb_value;
            ent[lsb_rob_entry].ready <= 1'b1;
          end
          // Issued last so a full-buffer issue into the slot freed by this
          // edge's commit wins over the free.
          if (do_issue) begin
            ent[tail] <= new_ent;
            tail      <= tail + ROB_BIT'(1);
          end
        end
        count <= count + (ROB_BIT+1)'(do_issue) - (ROB_BIT+1)'(do_commit);
      end
    end
  end

  assign rob_tail         = tail;
  assign rob_full         = (count == FULL_COUNT);
  assign rob_empty        = (count == '0);
  assign commit_reg_valid = reg_valid_q && rdy_in;
  assign commit_store     = store_q && rdy_in;
  assign rob_clear_up     = clear_q && rdy_in;

  // Operand lookup: stored value first, then same-cycle ALU, then LSB.
  for (genvar g = 0; g < 2; g++) begin : g_query
    logic [ROB_BIT-1:0] q;
    logic               r;
    logic [31:0]        v;
    assign q = (g == 0) ? query1_entry : query2_entry;
    always_comb begin
      r = 1'b0;
      v = '0;
      if (ent[q].busy) begin
        if (ent[q].ready) begin
          r = 1'b1;
          v = ent[q].value;
        end else if (rs_ready && rs_rob_entry == q) begin
          r = 1'b1;
          v = rs_value;
        end else if (lsb_ready && lsb_rob_entry == q) begin
          r = 1'b1;
          v = lsb_value;
        end
      end
    end
  end

  assign query1_ready = g_query[0].r;
  assign query1_value = g_query[0].v;
  assign query2_ready = g_query[1].r;
  assign query2_value = g_query[1].v;

endmodule

// File: tb/tb_rob.sv
module tb_rob;
  localparam int W = 10;  // {type[1:0], rd[4:0], tag[2:0]}

  logic        clk_in = 0;
  logic        rst_in = 1;
  logic        rdy_in = 1;
  logic        issue_signal = 0;
  logic [1:0]  issue_type = 0;
  logic [4:0]  issue_rd = 0;
  logic [31:0] issue_inst_addr = 0;
  logic        issue_pred_taken = 0;
  logic [31:0] issue_target = 0;
  logic        rs_ready = 0;
  logic [2:0]  rs_rob_entry = 0;
  logic [31:0] rs_value = 0;
  logic        lsb_ready = 0;
  logic [2:0]  lsb_rob_entry = 0;
  logic [31:0] lsb_value = 0;
  logic [2:0]  query1_entry = 0, query2_entry = 0;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_value, query2_value;
  logic [2:0]  rob_tail;
  logic        rob_full, rob_empty;
  logic        commit_reg_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_rob_entry;
  logic        commit_store;
  logic        rob_clear_up;
  logic [31:0] clear_pc;
  logic        rob_halt;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_signal(issue_signal), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_inst_addr(issue_inst_addr), .issue_pred_taken(issue_pred_taken),
    .issue_target(issue_target),
    .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .query1_entry(query1_entry), .query2_entry(query2_entry),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_value(query1_value), .query2_value(query2_value),
    .rob_tail(rob_tail), .rob_full(rob_full), .rob_empty(rob_empty),
    .commit_reg_valid(commit_reg_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_entry(commit_rob_entry),
    .commit_store(commit_store), .rob_clear_up(rob_clear_up),
    .clear_pc(clear_pc), .rob_halt(rob_halt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int tests_run = 0;
  int tests_failed = 0;
  int reg_commits = 0;
  int clear_pulses = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_val [8];
  logic [2:0]   sw_tail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    exp_q.delete();
    sw_tail = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                          input logic pred, input logic [31:0] tgt, input bit expect_commit);
    issue_signal = 1; issue_type = t; issue_rd = rd; issue_inst_addr = pc;
    issue_pred_taken = pred; issue_target = tgt;
    if (expect_commit) exp_q.push_back({t, rd, sw_tail});
    if (rdy_in) sw_tail++;
    tick();
    issue_signal = 0;
  endtask

  task automatic wb_rs(input logic [2:0] tag, input logic [31:0] val);
    rs_ready = 1; rs_rob_entry = tag; rs_value = val;
    model_val[tag] = val;
    tick();
    rs_ready = 0;
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk_in) begin
    logic [W-1:0] e;
    #1;
    if (rob_clear_up) clear_pulses++;
    if (commit_reg_valid || commit_store) begin
      check("commit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("commit_tag", 32'(commit_rob_entry), 32'(e[2:0]));
        if (commit_reg_valid) begin
          reg_commits++;
          check("commit_kind_reg", 32'(e[9:8]), 32'd0);
          check("commit_rd", 32'(commit_rd), 32'(e[7:3]));
          check("commit_value", commit_value, model_val[e[2:0]]);
        end else begin
          check("commit_kind_store", 32'(e[9:8]), 32'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    for (int i = 0; i < 8; i++) model_val[i] = 0;
    do_reset();
    check("rst_empty", 32'(rob_empty), 1);
    check("rst_full", 32'(rob_full), 0);
    check("rst_tail", 32'(rob_tail), 0);
    check("rst_regv", 32'(commit_reg_valid), 0);
    check("rst_store", 32'(commit_store), 0);
    check("rst_clear", 32'(rob_clear_up), 0);
    check("rst_halt", 32'(rob_halt), 0);
    check("rst_q1rdy", 32'(query1_ready), 0);

    // single REG commit
    do_issue(2'd0, 5'd5, 32'h0, 0, 0, 1);
    wb_rs(3'd0, 32'h1234);
    check("single_nocommit_yet", 32'(commit_reg_valid), 0);
    tick();
    check("single_regv", 32'(commit_reg_valid), 1);
    check("single_rd", 32'(commit_rd), 5);
    check("single_val", commit_value, 32'h1234);
    check("single_empty", 32'(rob_empty), 1);

    // out-of-order write-back, in-order commit
    do_issue(2'd0, 5'd6, 32'h4, 0, 0, 1);   // tag1
    do_issue(2'd0, 5'd7, 32'h8, 0, 0, 1);   // tag2
    c0 = reg_commits;
    wb_rs(3'd2, 32'd7);
    tick(); tick(); tick();
    check("ooo_no_commit", 32'(reg_commits), 32'(c0));
    wb_rs(3'd1, 32'd3);
    tick();
    check("ooo_first_v", 32'(commit_reg_valid), 1);
    check("ooo_first_tag", 32'(commit_rob_entry), 1);
    tick();
    check("ooo_second_v", 32'(commit_reg_valid), 1);
    check("ooo_second_tag", 32'(commit_rob_entry), 2);
    tick();
    check("ooo_idle", 32'(commit_reg_valid), 0);
    check("ooo_empty", 32'(rob_empty), 1);

    // fill, then issue on the commit edge while full
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(2'd0, 5'(i + 1), 32'(i * 4), 0, 0, 1);
    check("fill_full", 32'(rob_full), 1);
    check("fill_tail", 32'(rob_tail), 0);
    check("fill_empty", 32'(rob_empty), 0);
    wb_rs(3'd0, 32'hA0 + 32'($urandom_range(0, 15)));
    do_issue(2'd0, 5'd20, 32'h40, 0, 0, 1);
    check("full_issue_commit_full", 32'(rob_full), 1);
    check("full_issue_commit_tail", 32'(rob_tail), 1);
    check("full_model_tail", 32'(rob_tail), 32'(sw_tail));

    // mispredict: predicted not-taken, actually taken
    do_reset();
    c0 = clear_pulses;
    do_issue(2'd2, 5'd0, 32'h40, 0, 32'h100, 0);  // tag0 branch
    do_issue(2'd0, 5'd9, 32'h44, 0, 0, 0);        // tag1 younger, flushed
    wb_rs(3'd1, 32'd5);
    wb_rs(3'd0, 32'd1);
    tick();
    check("mp_clear", 32'(rob_clear_up), 1);
    check("mp_pc", clear_pc, 32'h100);
    check("mp_empty", 32'(rob_empty), 1);
    check("mp_tail", 32'(rob_tail), 0);
    sw_tail = 0;
    tick(); tick();
    check("mp_one_pulse", 32'(clear_pulses - c0), 1);
    check("mp_after_empty", 32'(rob_empty), 1);

    // mispredict: predicted taken, actually not taken
    do_issue(2'd2, 5'd0, 32'h80, 1, 32'h300, 0);
    wb_rs(3'd0, 32'd0);
    tick();
    check("mp2_clear", 32'(rob_clear_up), 1);
    check("mp2_pc", clear_pc, 32'h84);
    sw_tail = 0;

    // correctly predicted branch: no pulse
    do_reset();
    c0 = clear_pulses;
    do_issue(2'd2, 5'd0, 32'h90, 1, 32'h200, 0);
    wb_rs(3'd0, 32'd1);
    tick(); tick();
    check("bok_no_clear", 32'(clear_pulses - c0), 0);
    check("bok_empty", 32'(rob_empty), 1);

    // query forwarding
    do_reset();
    do_issue(2'd0, 5'd1, 0, 0, 0, 0);
    do_issue(2'd0, 5'd2, 0, 0, 0, 0);
    do_issue(2'd0, 5'd3, 0, 0, 0, 0);
    query1_entry = 3'd2; query2_entry = 3'd2;
    #1;
    check("q_busy_notready", 32'(query2_ready), 0);
    lsb_ready = 1; lsb_rob_entry = 3'd2; lsb_value = 32'd7;
    #1;
    check("q_lsb_fwd_rdy", 32'(query1_ready), 1);
    check("q_lsb_fwd_val", query1_value, 32'd7);
    @(posedge clk_in); #1;
    lsb_ready = 0;
    #1;
    check("q_stored_rdy", 32'(query2_ready), 1);
    check("q_stored_val", query2_value, 32'd7);
    query1_entry = 3'd1;
    rs_ready = 1; rs_rob_entry = 3'd1; rs_value = 32'h55;
    #1;
    check("q_rs_fwd_val", query1_value, 32'h55);
    rs_ready = 0;
    query1_entry = 3'd5;
    #1;
    check("q_idle_rdy", 32'(query1_ready), 0);
    check("q_idle_val", query1_value, 0);
    query1_entry = 0; query2_entry = 0;

    // store commit, then EXIT halts further commits
    do_reset();
    do_issue(2'd1, 5'd0, 32'h10, 0, 0, 1);
    tick();
    check("st_pulse", 32'(commit_store), 1);
    check("st_tag", 32'(commit_rob_entry), 0);
    do_issue(2'd3, 5'd0, 32'h14, 0, 0, 0);
    tick();
    check("exit_halt", 32'(rob_halt), 1);
    do_issue(2'd1, 5'd0, 32'h18, 0, 0, 0);
    tick(); tick();
    check("halt_sticky", 32'(rob_halt), 1);
    check("halt_no_commit", 32'(rob_empty), 0);
    do_reset();
    check("halt_cleared", 32'(rob_halt), 0);

    // paused: issue ignored
    rdy_in = 0;
    do_issue(2'd0, 5'd4, 0, 0, 0, 0);
    check("pause_tail", 32'(rob_tail), 0);
    check("pause_empty", 32'(rob_empty), 1);
    rdy_in = 1;
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
